// File: rtl/alu_slice_seq.sv
// Sequential ALU: WIDTH-bit operands processed LSB-first through LANES 4-bit function slices per clock.
// Optional signed-overflow flag is generated when ALU_SLICE_SEQ_OVF_EN is defined; otherwise v is tied low.
module alu_slice_seq #(
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             v
);

    localparam int SW = 4 * LANES;
    localparam int N  = WIDTH / SW;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % SW) != 0 || N < 1) begin : g_bad_cfg
            $error("alu_slice_seq: WIDTH must be a positive multiple of 4*LANES");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] f_reg;
    logic             cout_reg;
    logic             zero_reg;
    logic             done_reg;

    int               base;
    logic [SW-1:0]    a_sl;
    logic [SW-1:0]    b_sl;
    logic [SW-1:0]    p;
    logic [SW-1:0]    g;
    logic [SW-1:0]    h;
    logic [SW-1:0]    f_sl;
    logic [SW:0]      c;
    logic [WIDTH-1:0] f_merged;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        load = (state_reg == IDLE) && start;
        step = (state_reg == RUN);
        last = step && (k_reg == KW'(N - 1));
    end

    // ---------------- slice datapath ----------------
    always_comb begin
        base = int'(k_reg) * SW;
        a_sl = a_reg[base +: SW];
        b_sl = b_reg[base +: SW];
    end

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_bit
            assign p[gi] = a_sl[gi] | (b_sl[gi] & s_reg[0]) | (~b_sl[gi] & s_reg[1]);
            assign g[gi] = a_sl[gi] & ((b_sl[gi] & s_reg[3]) | (~b_sl[gi] & s_reg[2]));
            assign h[gi] = p[gi] ^ g[gi];
        end
    endgenerate

    // Carry ripples through every lane in this step even in logic mode, so cout is defined for m=1 too.
    always_comb begin
        c    = '0;
        f_sl = '0;
        c[0] = carry_reg;
        for (int i = 0; i < SW; i++) begin
            c[i+1]  = p[i] & (c[i] | g[i]);
            f_sl[i] = h[i] ^ (c[i] | m_reg);
        end
    end

    always_comb begin
        f_merged              = f_reg;
        f_merged[base +: SW]  = f_sl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
            f_reg     <= '0;
            cout_reg  <= 1'b0;
            zero_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                a_reg     <= a;
                b_reg     <= b;
                s_reg     <= s;
                m_reg     <= m;
                carry_reg <= cin;
                k_reg     <= '0;
            end
            if (step) begin
                f_reg     <= f_merged;
                carry_reg <= c[SW];
                k_reg     <= k_reg + KW'(1);
                if (last) begin
                    cout_reg <= c[SW];
                    zero_reg <= (f_merged == '0);
                    done_reg <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_SLICE_SEQ_OVF_EN
    logic v_reg;

    // c[SW-1] is the carry into the operand MSB during the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg <= 1'b0;
        end else if (last) begin
            v_reg <= m_reg ? 1'b0 : (c[SW-1] ^ c[SW]);
        end
    end

    assign v = v_reg;
`else
    assign v = 1'b0;
`endif

    assign done = done_reg;
    assign f    = f_reg;
    assign cout = cout_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Scoreboard bench for alu_slice_seq: a 16-bit/1-lane instance (N=4) and a 32-bit/8-lane instance (N=1).
module tb_alu_slice_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s = '0;
    logic        m = 1'b0;
    logic        cin = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, cout16, zero16, v16;
    logic [15:0] f16;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, cout32, zero32, v32;
    logic [31:0] f32;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] f;
        logic        cout;
        logic        zero;
        logic        v;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];

`ifdef ALU_SLICE_SEQ_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    alu_slice_seq #(.WIDTH(16), .LANES(1)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
        .s(s), .m(m), .cin(cin), .busy(busy16), .done(done16),
        .f(f16), .cout(cout16), .zero(zero16), .v(v16)
    );

    alu_slice_seq #(.WIDTH(32), .LANES(8)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
        .s(s), .m(m), .cin(cin), .busy(busy32), .done(done32),
        .f(f32), .cout(cout32), .zero(zero32), .v(v32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference of the function-select ALU.
    function automatic exp_t model(input int w, input logic [31:0] ua, input logic [31:0] ub,
                                   input logic [3:0] us, input logic um, input logic uc);
        exp_t e;
        logic cc, cprev, pp, gg, hh;
        e.f = '0;
        cc = uc;
        cprev = uc;
        for (int i = 0; i < w; i++) begin
            pp = ua[i] | (ub[i] & us[0]) | (~ub[i] & us[1]);
            gg = ua[i] & ((ub[i] & us[3]) | (~ub[i] & us[2]));
            hh = pp ^ gg;
            e.f[i] = hh ^ (cc | um);
            cprev = cc;
            cc = pp & (cc | gg);
        end
        e.cout = cc;
        e.zero = (e.f == 32'd0);
        e.v = OVF_ON & ~um & (cprev ^ cc);
        e.due = 0;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at #1 after an edge; leaves start low at #1 after the accepting edge.
    task automatic drive16(input logic [15:0] ua, input logic [15:0] ub, input logic [3:0] us,
                           input logic um, input logic uc, input exp_t e);
        exp_t x;
        x = e;
        x.due = cyc + 1 + 4;
        a16 = ua; b16 = ub; s = us; m = um; cin = uc;
        start16 = 1'b1;
        q16.push_back(x);
        tick(1);
        start16 = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] ua, input logic [31:0] ub, input logic [3:0] us,
                           input logic um, input logic uc, input exp_t e);
        exp_t x;
        x = e;
        x.due = cyc + 1 + 1;
        a32 = ua; b32 = ub; s = us; m = um; cin = uc;
        start32 = 1'b1;
        q32.push_back(x);
        tick(1);
        start32 = 1'b0;
    endtask

    task automatic wait_idle(input logic is32);
        int t;
        t = 0;
        while (t < 40 && (is32 ? (q32.size() != 0 || busy32) : (q16.size() != 0 || busy16))) begin
            tick(1);
            t++;
        end
        if (is32) check("timeout32_pending", q32.size(), 0);
        else      check("timeout16_pending", q16.size(), 0);
    endtask

    function automatic exp_t mk(input logic [31:0] ef, input logic ec, input logic ez, input logic ev);
        exp_t e;
        e.f = ef; e.cout = ec; e.zero = ez; e.v = ev; e.due = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (done16) begin
            if (q16.size() == 0) begin
                check("done16_unexpected", {31'd0, done16}, 32'd0);
            end else begin
                e = q16.pop_front();
                $display("op16 done cyc=%0d f=%h cout=%b zero=%b v=%b", cyc, f16, cout16, zero16, v16);
                check("f16", {16'd0, f16}, e.f);
                check("cout16", {31'd0, cout16}, {31'd0, e.cout});
                check("zero16", {31'd0, zero16}, {31'd0, e.zero});
                check("v16", {31'd0, v16}, {31'd0, e.v});
                check("latency16", cyc, e.due);
                check("busy16_at_done", {31'd0, busy16}, 32'd0);
            end
        end
        if (done32) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", {31'd0, done32}, 32'd0);
            end else begin
                e = q32.pop_front();
                $display("op32 done cyc=%0d f=%h cout=%b zero=%b v=%b", cyc, f32, cout32, zero32, v32);
                check("f32", f32, e.f);
                check("cout32", {31'd0, cout32}, {31'd0, e.cout});
                check("zero32", {31'd0, zero32}, {31'd0, e.zero});
                check("v32", {31'd0, v32}, {31'd0, e.v});
                check("latency32", cyc, e.due);
                check("busy32_at_done", {31'd0, busy32}, 32'd0);
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] wa, wb;
        logic [3:0]  rs;
        logic        rm, rc;

        tick(3);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy16}, 32'd0);
        check("rst_done", {31'd0, done16}, 32'd0);
        check("rst_f", {16'd0, f16}, 32'd0);
        check("rst_cout", {31'd0, cout16}, 32'd0);
        check("rst_zero", {31'd0, zero16}, 32'd1);
        check("rst_v", {31'd0, v16}, 32'd0);
        check("rst_zero32", {31'd0, zero32}, 32'd1);

        // Reference vectors with hand-derived results
        drive16(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b0, OVF_ON));
        check("busy16_after_start", {31'd0, busy16}, 32'd1);
        wait_idle(1'b0);
        drive16(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, mk(32'h0000, 1'b1, 1'b1, 1'b0));
        wait_idle(1'b0);
        drive16(16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b0, mk(32'h3030, 1'b1, 1'b0, 1'b0));
        wait_idle(1'b0);
        drive16(16'hF0F0, 16'h3C3C, 4'b0110, 1'b1, 1'b0, mk(32'hCCCC, 1'b1, 1'b0, 1'b0));
        wait_idle(1'b0);

        // Starts during busy are ignored; a start in the done cycle is accepted
        drive16(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, mk(32'h3333, 1'b0, 1'b0, 1'b0));
        a16 = 16'hFFFF; b16 = 16'hFFFF; s = 4'b0110; m = 1'b1; cin = 1'b1;
        start16 = 1'b1;
        tick(2);
        start16 = 1'b0;
        tick(2);
        check("done16_cycle_b2b", {31'd0, done16}, 32'd1);
        drive16(16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0, mk(32'h0FF0, 1'b0, 1'b0, 1'b0));
        check("busy16_b2b", {31'd0, busy16}, 32'd1);
        check("done16_fell_b2b", {31'd0, done16}, 32'd0);
        wait_idle(1'b0);

        // Reset in the middle of an operation
        drive16(16'h0101, 16'h0202, 4'b1001, 1'b0, 1'b0, mk(32'h0303, 1'b0, 1'b0, 1'b0));
        tick(1);
        reset = 1'b1;
        tick(1);
        q16.delete();
        check("abort_busy", {31'd0, busy16}, 32'd0);
        check("abort_done", {31'd0, done16}, 32'd0);
        check("abort_f", {16'd0, f16}, 32'd0);
        check("abort_zero", {31'd0, zero16}, 32'd1);
        reset = 1'b0;
        tick(8);
        drive16(16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b1, mk(32'hBCDF, 1'b0, 1'b0, 1'b0));
        wait_idle(1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            drive16(ra, rb, rs, rm, rc, model(16, {16'd0, ra}, {16'd0, rb}, rs, rm, rc));
            wait_idle(1'b0);
        end

        // Single-step configuration
        drive32(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b1, 1'b0));
        wait_idle(1'b1);
        drive32(32'h7FFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b0, OVF_ON));
        wait_idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            wa = $urandom; wb = $urandom; rs = 4'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            drive32(wa, wb, rs, rm, rc, model(32, wa, wb, rs, rm, rc));
            wait_idle(1'b1);
        end

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
